// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM state encoding and access sizes.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC_LO,
    ACC_HI,
    DONE
  } lsu_state_t;

  localparam logic BYTE = 1'b0;
  localparam logic WORD = 1'b1;

endpackage

// File: rtl/load_store_unit.sv
// Load/store sequencer between execute and the 256-byte data_memory.
// Accepts one request at a time, drives the memory pins and returns load
// results to writeback with the destination tag.
// Optional feature: define LSU_WORD_EN to enable 16-bit little-endian
// accesses split into two byte accesses (low byte first).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_word,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  input  logic [REG_W-1:0]  req_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic [15:0]       wb_data
);

  lsu_state_t       state;
  logic             write_q;
  logic [REG_W-1:0] rd_q;

`ifdef LSU_WORD_EN
  logic       size_q;
  logic [7:0] wdata_hi_q;
  logic [7:0] result_lo;
`else
  logic unused_word_bits;
  assign unused_word_bits = ^{req_word, req_wdata[15:8]};
`endif

  // Write strobe is only live while an access state is driving a store.
  always_comb begin
    mem_we = 1'b0;
    if (write_q && (state == ACC_LO || state == ACC_HI)) begin
      mem_we = 1'b1;
    end
  end

  // Sequencer FSM with registered memory address/data and writeback outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      write_q   <= 1'b0;
      rd_q      <= '0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= 16'h0000;
`ifdef LSU_WORD_EN
      size_q     <= BYTE;
      wdata_hi_q <= 8'h00;
      result_lo  <= 8'h00;
`endif
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            rd_q      <= req_rd;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata[7:0];
`ifdef LSU_WORD_EN
            size_q     <= req_word ? WORD : BYTE;
            wdata_hi_q <= req_wdata[15:8];
`endif
            req_ready <= 1'b0;
            state     <= ACC_LO;
          end
        end
        ACC_LO: begin
`ifdef LSU_WORD_EN
          if (size_q == WORD) begin
            result_lo <= mem_rdata;
            mem_addr  <= mem_addr + 1'b1;
            mem_wdata <= wdata_hi_q;
            state     <= ACC_HI;
          end else begin
            state <= DONE;
            if (!write_q) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
              wb_data  <= {8'h00, mem_rdata};
            end
          end
`else
          state <= DONE;
          if (!write_q) begin
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= {8'h00, mem_rdata};
          end
`endif
        end
`ifdef LSU_WORD_EN
        ACC_HI: begin
          state <= DONE;
          if (!write_q) begin
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= {mem_rdata, result_lo};
          end
        end
`endif
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural byte memory
// and a scoreboard of expected writeback results.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_word;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [2:0]  req_rd;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ref_mem[256];
  logic [7:0] mem[256];
  int         cyc = 0;
  int         assertions = 0;
  int         failures = 0;
  int         last_acc = -1;
  int         last_lat = 0;

  load_store_unit #(.ADDR_W(8), .REG_W(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_word(req_word),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural data_memory: combinational read, clocked write, cleared on reset.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    assertions++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a writeback.
  initial begin
    forever begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_wb", 32'(wb_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("wb_rd", 32'(wb_rd), 32'(e.rd));
          checkOutput("wb_data", 32'(wb_data), 32'(e.data));
          checkOutput("wb_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Issues one request, updates the reference model and checks the busy window.
  task automatic applyStimulus(input bit wr, input bit wd, input logic [7:0] a,
                               input logic [15:0] wdat, input logic [2:0] rd, input bit b2b);
    bit   word_eff;
    bit   seen;
    int   tries;
    int   lat;
    int   acc_cyc;
    exp_t e;
`ifdef LSU_WORD_EN
    word_eff = wd;
`else
    word_eff = 1'b0;
`endif
    lat = word_eff ? 2 : 1;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_word  = wd;
    req_addr  = a;
    req_wdata = wdat;
    req_rd    = rd;
    seen  = 1'b0;
    tries = 0;
    while (!seen && tries < 20) begin
      seen = req_ready;
      @(posedge clk);
      #1;
      if (!seen) begin
        tries++;
        @(negedge clk);
      end
    end
    if (!seen) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      return;
    end
    acc_cyc = cyc;
    if (b2b && last_acc >= 0) begin
      checkOutput("throughput", 32'(acc_cyc - last_acc), 32'(last_lat + 2));
    end
    last_acc = acc_cyc;
    last_lat = lat;
    if (wr) begin
      ref_mem[a] = wdat[7:0];
      if (word_eff) ref_mem[8'(a + 8'd1)] = wdat[15:8];
    end else begin
      e.rd   = rd;
      e.data = word_eff ? {ref_mem[8'(a + 8'd1)], ref_mem[a]} : {8'h00, ref_mem[a]};
      e.cyc  = acc_cyc + lat;
      exp_q.push_back(e);
    end
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      checkOutput("ready_busy", 32'(req_ready), 32'd0);
      checkOutput("mem_we", 32'(mem_we), 32'((wr && k < lat) ? 1 : 0));
      if (k < lat) checkOutput("mem_addr", 32'(mem_addr), 32'(8'(a + 8'(k))));
    end
  endtask

  task automatic idleCycles(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    last_acc  = -1;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    checkOutput({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    checkOutput({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    checkOutput({tag, "_wb_data"}, 32'(wb_data), 32'd0);
  endtask

  // Starts a load, then resets while it is in its first access cycle.
  task automatic resetMidLoad();
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_word  = 1'b0;
    req_addr  = 8'h20;
    req_rd    = 3'd6;
    checkOutput("pre_reset_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
    checkOutput("acc_lo_busy", 32'(req_ready), 32'd0);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    checkResetValues("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkResetValues("after_reset");
    last_acc = -1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    int waits;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_word  = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 16'h0000;
    req_rd    = 3'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    #1;
    checkResetValues("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkResetValues("post_reset");

    $display("[TB] directed byte and word accesses");
    applyStimulus(1'b1, 1'b0, 8'h10, 16'h00A5, 3'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h10, 16'h0000, 3'd3, 1'b1);
    idleCycles(2);
    applyStimulus(1'b1, 1'b1, 8'h20, 16'hBEEF, 3'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h20, 16'h0000, 3'd5, 1'b1);
    idleCycles(2);
    applyStimulus(1'b1, 1'b1, 8'hFF, 16'h1234, 3'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hFF, 16'h0000, 3'd1, 1'b1);
    idleCycles(2);
    checkOutput("mem_20", 32'(mem[8'h20]), 32'(ref_mem[8'h20]));
    checkOutput("mem_21", 32'(mem[8'h21]), 32'(ref_mem[8'h21]));
    checkOutput("mem_FF", 32'(mem[8'hFF]), 32'(ref_mem[8'hFF]));
    checkOutput("mem_00", 32'(mem[8'h00]), 32'(ref_mem[8'h00]));

    $display("[TB] continuous alternating byte requests");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i[0] ? 1'b0 : 1'b1, 1'b0, 8'(8'h40 + 8'(i / 2)),
                    16'($urandom), 3'($urandom), 1'b1);
    end
    idleCycles(3);

    $display("[TB] reset during a load");
    resetMidLoad();
    repeat (3) @(negedge clk);
    checkOutput("no_wb_after_reset", 32'(exp_q.size()), 32'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 8'(8'hFC + 8'($urandom_range(0, 7))),
                    16'($urandom), 3'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(0, 2));
    end
    idleCycles(4);

    waits = 0;
    while (exp_q.size() != 0 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_mem[i]) bad++;
    end
    checkOutput("memory_contents", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
